// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory responder: valid/ready request, fixed-latency single-cycle response
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (reject accesses whose byte address is not word aligned)
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
  output logic                    o_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_resp_rdata,
  output logic                    o_resp_error,
  output logic                    o_busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_init_done;
  logic                  r_write;
  logic [IDX_W+1:0]      r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTES-1:0]      r_wstrb;
  logic                  r_busy;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_error;

  // Storage is deliberately outside the reset domain: reset never alters contents.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH_WORDS-1];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_sel_write;
  logic [IDX_W+1:0]      w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [BYTES-1:0]      w_sel_wstrb;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign;
  logic                  w_mem_we;
  logic                  w_unused_bits;

  // Ready depends only on registered state, never on the request inputs.
  assign o_req_ready = (r_state == S_IDLE) && r_init_done;
  assign w_accept    = i_req_valid && o_req_ready;

  // With LATENCY=1 the access happens on the accept edge itself, so the live
  // request fields are used; otherwise the latched copy is used.
  assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == 4'd1)) ||
                        (w_accept && (LATENCY == 1));
  assign w_sel_write  = (r_state == S_IDLE) ? i_req_write             : r_write;
  assign w_sel_addr   = (r_state == S_IDLE) ? i_req_addr[IDX_W+1:0]   : r_addr;
  assign w_sel_wdata  = (r_state == S_IDLE) ? i_req_wdata             : r_wdata;
  assign w_sel_wstrb  = (r_state == S_IDLE) ? i_req_wstrb             : r_wstrb;
  assign w_idx        = w_sel_addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = (w_sel_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Upper address bits wrap away; the low byte-offset bits only matter to the misalign check.
  assign w_unused_bits = ^{i_req_addr[ADDR_WIDTH-1:IDX_W+2], w_sel_addr[1:0]};

  assign w_mem_we = w_enter_resp && w_sel_write && !w_misalign;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_error = r_resp_error;
  assign o_busy       = r_busy;

  // Byte-enabled storage write, committed on the edge that enters RESP.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_sel_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request FSM IDLE -> WAIT -> RESP -> IDLE with registered response outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_init_done  <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= i_req_write;
            r_addr  <= i_req_addr[IDX_W+1:0];
            r_wdata <= i_req_wdata;
            r_wstrb <= i_req_wstrb;
            r_busy  <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_resp_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_error <= w_misalign;
        r_resp_rdata <= (w_sel_write || w_misalign) ? '0 : r_mem[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic [3:0]  i_req_wstrb = 4'h0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_error;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_error(o_resp_error), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Issue one request at a negedge and wait (bounded) for its response pulse.
  // lat = number of falling edges after the accept edge until resp_valid is seen (0 = never).
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int lat, output logic busy_ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    i_req_write = w; i_req_addr = a; i_req_wdata = d; i_req_wstrb = s; i_req_valid = 1'b1;
    lat = 0; busy_ok = 1'b1; rd = 32'hx; err = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) i_req_valid = 1'b0;
      if (!o_busy) busy_ok = 1'b0;
      if (o_resp_valid) begin
        lat = k; rd = o_resp_rdata; err = o_resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({o_req_ready, o_resp_valid, o_resp_error, o_busy, o_resp_rdata} !== 36'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got ready=%b valid=%b err=%b busy=%b rdata=%h, want all 0",
                 c, o_req_ready, o_resp_valid, o_resp_error, o_busy, o_resp_rdata);
      end
    end
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (o_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_first_edge: got %b want 0", o_req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_first_edge: got %b want 1", o_req_ready);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic err; int lat; logic bok;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, bok);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL write_latency: got %0d want 2", lat); end
    n_checks++;
    if (bok !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", bok); end
    n_checks++;
    if ({err, rd} !== 33'h0) begin
      n_fail++; $display("FAIL write_resp: got err=%b rdata=%h want err=0 rdata=0", err, rd);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL read_latency: got %0d want 2", lat); end
    n_checks++;
    if (bok !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b want 1", bok); end
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", rd); end
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_resp_valid, o_req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL after_resp: got busy=%b valid=%b ready=%b want 0 0 1", o_busy, o_resp_valid, o_req_ready);
    end
  endtask

  task automatic test_byte_strobe;
    logic [31:0] rd; logic err; int lat; logic bok;
    do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, err, lat, bok);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL strobe_read: got %h want deadbeaa", rd); end
  endtask

  task automatic test_hold_valid;
    logic [31:0] rd; logic err; int lat; logic bok; int pulses; int n;
    do_req(1'b1, 32'h44, 32'hCAFEF00D, 4'hF, rd, err, lat, bok);
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    i_req_write = 1'b1; i_req_addr = 32'h40; i_req_wdata = 32'h11111111; i_req_wstrb = 4'hF;
    i_req_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_resp_valid) begin
        pulses++;
        i_req_valid = 1'b0;
      end else if (i_req_valid) begin
        i_req_addr  = i_req_addr + 32'd4;
        i_req_wdata = 32'h22222222;
      end
    end
    i_req_valid = 1'b0;
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'h11111111) begin n_fail++; $display("FAIL hold_first_served: got %h want 11111111", rd); end
    do_req(1'b0, 32'h44, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL hold_ignored: got %h want cafef00d", rd); end
    do_req(1'b0, 32'h1010, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL alias_read: got %h want deadbeaa", rd); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic err; int lat; logic bok; int n; int pulses;
    do_req(1'b1, 32'h20, 32'h12345678, 4'hF, rd, err, lat, bok);
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    i_req_write = 1'b1; i_req_addr = 32'h20; i_req_wdata = 32'hFFFFFFFF; i_req_wstrb = 4'hF;
    i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_in_wait: got %b want 1", o_busy); end
    i_reset = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_resp_valid, o_req_ready} !== 3'b000) begin
      n_fail++; $display("FAIL abort_async_clear: got busy=%b valid=%b ready=%b want 0 0 0", o_busy, o_resp_valid, o_req_ready);
    end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_resp_valid) pulses++;
    end
    i_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d pulses want 0", pulses); end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL abort_no_write: got %h want 12345678", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic err; int lat; logic bok;
    do_req(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, err, lat, bok);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL misalign_latency: got %0d want 2", lat); end
`ifdef DMEM_MISALIGN_CHECK_EN
    n_checks++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL misalign_reject: got err=%b rdata=%h want err=1 rdata=0", err, rd);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL misalign_unchanged: got %h want deadbeaa", rd); end
`else
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL misalign_err: got %b want 0", err); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL misalign_written: got %h want ffffffff", rd); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic err; int lat; logic bok;
    do_req(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, rd, err, lat, bok);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL raw_read: got %h want a5a5a5a5", rd); end
    do_req(1'b1, 32'h30, 32'h0, 4'b0000, rd, err, lat, bok);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL zero_strobe_resp: got latency %0d want 2", lat); end
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL zero_strobe_unchanged: got %h want a5a5a5a5", rd); end
    do_req(1'b1, 32'h34, 32'h0BADF00D, 4'b1100, rd, err, lat, bok);
    do_req(1'b0, 32'h34, 32'h0, 4'h0, rd, err, lat, bok);
    n_checks++;
    if (rd[31:16] !== 16'h0BAD) begin n_fail++; $display("FAIL upper_strobe: got %h want 0bad", rd[31:16]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_hold_valid();
    test_reset_abort();
    test_misalign();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
